cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
Host-side run controller that drives the CPU's `enable` input and watches its `finish` output. It is the initiator end of the CPU enable/finish interface. On a start request it holds the CPU disabled for a settle window, then asserts enable and counts run cycles until the CPU reports finish or a timeout fires. It then parks in a done state with the result flags and cycle count visible to the IO/host logic.

Parameters:
CYCLE_W, 32, width of the run-cycle counter.
TIMEOUT, 100000, maximum run cycles before forced stop; legal range 1 to 2^CYCLE_W-1.
SETTLE_CYCLES, 2, number of clk edges cpu_enable stays low after an accepted start; legal range >= 1.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  run request; sampled on clk; acted on only in IDLE or DONE.
abort  in  1  force stop; acted on in any state; has priority over start.
cpu_enable  out  1  drives the CPU's enable input; registered.
cpu_finish  in  1  the CPU's finish output; same clock domain, no synchroniser.
busy  out  1  high in SETTLE and RUN.
done  out  1  high in DONE.
timeout  out  1  high in DONE when the run ended by timeout.
cycle_count  out  CYCLE_W  number of RUN-state edges in the current/last run.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - cpu_enable=0, busy=0, done=0, timeout=0, cycle_count=0.
  - The async assert takes effect immediately, including mid-run: cpu_enable drops without waiting for a clock edge.
- States: IDLE, SETTLE, RUN, DONE. Transitions are evaluated at each rising edge; priority is abort > finish > timeout > start.
- IDLE:
  - start=1 -> SETTLE.
  - Load the settle counter with SETTLE_CYCLES-1 and clear cycle_count to 0.
- SETTLE:
  - cpu_enable=0.
  - Counter decrements each edge. When it is 0 at an edge, go to RUN and set cpu_enable=1 at that edge.
  - Net effect: start sampled at edge k gives cpu_enable=1 from edge k+SETTLE_CYCLES.
  - start is ignored in this state.
- RUN:
  - cpu_enable=1 and cycle_count increments by 1 at every edge spent in RUN, including the exiting edge.
  - cpu_finish=1 at an edge -> DONE. cpu_enable=0, done=1, timeout=0.
  - Otherwise, cycle_count==TIMEOUT-1 at an edge -> DONE. cpu_enable=0, done=1, timeout=1, so cycle_count ends at TIMEOUT.
  - finish and the timeout limit on the same edge -> finish wins (timeout=0).
  - cpu_finish already high on the first RUN edge -> DONE with cycle_count=1.
  - start is ignored in this state.
- DONE:
  - done, timeout and cycle_count are held.
  - start=1 -> SETTLE as from IDLE: done and timeout clear, cycle_count clears.
- abort=1 in any state -> IDLE at that edge:
  - cpu_enable=0, done=0, timeout=0.
  - cycle_count retains its value.
  - An abort on the same edge as finish wins; the result is IDLE, not DONE.
- cycle_count never wraps, because TIMEOUT <= 2^CYCLE_W-1.
- cpu_finish is ignored outside RUN.

Decomposition:
- Shared package `cpu_io_pkg` holds:
  - the state encoding constants (IDLE=0, SETTLE=1, RUN=2, DONE=3);
  - default CYCLE_W.
- Sub-module `down_counter`: a loadable settle counter with a zero flag. The run counter stays inline because of its compare-to-TIMEOUT logic.

Test Plan:
1. Reset release, then start pulse at edge k; CPU model raises finish 10 cycles after enable rises. Required: cpu_enable=1 from edge k+2, then done=1, timeout=0, cycle_count=10, cpu_enable=0.
2. TIMEOUT=20 and the CPU model never finishes. Required: timeout=1, done=1, cycle_count=20, cpu_enable low exactly 20 edges after it rose.
3. TIMEOUT=5 and finish rises on the 5th RUN edge. Required: done=1, timeout=0, cycle_count=5 (finish beats timeout).
4. Abort 3 cycles into RUN. Required: IDLE, cpu_enable=0, done=0, cycle_count=3. Also, rst_n pulsed low mid-RUN (no clock edge) -> cpu_enable=0 immediately and all outputs 0.
5. In DONE with cycle_count=10, start pulse. Required: done=0 and cycle_count=0 next edge; a second run completes normally with the new count. Also, start pulses during SETTLE/RUN -> no effect.
6. cpu_finish held high before enable rises. Required: no effect during SETTLE; DONE with cycle_count=1 on the first RUN edge.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: shared state encoding and default widths for the CPU enable/finish interface
package cpu_io_pkg;
    localparam int CYCLE_W_DEF = 32;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/down_counter.sv
// down_counter: loadable down counter that stops at zero and flags it
module down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;
    // load wins over decrement; decrement saturates at zero
    always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign zero = cnt_q == '0;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: start/settle/run/done controller driving CPU enable and watching finish
module cpu_run_ctrl
    import cpu_io_pkg::*;
#(
    parameter int CYCLE_W       = CYCLE_W_DEF,
    parameter int TIMEOUT       = 100000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               cpu_enable,
    input  logic               cpu_finish,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CYCLE_W-1:0] cycle_count
);
    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [SW-1:0]      SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] LIMIT       = CYCLE_W'(TIMEOUT - 1);
    state_t             state_q, state_d;
    logic [CYCLE_W-1:0] cnt_q, cnt_d;
    logic               tmo_q, tmo_d;
    logic               en_q, en_d;
    logic               settle_load, settle_dec, settle_zero;
    down_counter #(.W(SW)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (settle_load),
        .dec      (settle_dec),
        .load_val (SETTLE_LOAD),
        .zero     (settle_zero)
    );
    // state, result and enable registers; async reset drops enable immediately
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            en_q    <= en_d;
        end
    // next state: abort > finish > timeout > start; abort keeps the run count
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            tmo_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE:
                    if (start) begin
                        state_d     = ST_SETTLE;
                        cnt_d       = '0;
                        tmo_d       = 1'b0;
                        settle_load = 1'b1;
                    end
                ST_SETTLE: begin
                    state_d    = settle_zero ? ST_RUN : ST_SETTLE;
                    settle_dec = !settle_zero;
                end
                ST_RUN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cpu_finish) state_d = ST_DONE;
                    else if (cnt_q == LIMIT) begin
                        state_d = ST_DONE;
                        tmo_d   = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        en_d = state_d == ST_RUN;
    end
    // outputs decoded from registered state
    always_comb begin
        cpu_enable  = en_q;
        busy        = state_q == ST_SETTLE || state_q == ST_RUN;
        done        = state_q == ST_DONE;
        timeout     = tmo_q;
        cycle_count = cnt_q;
    end
endmodule
